dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port 512x19 data memory.
- Port 0 serves the CPU load/store stage. Port 1 serves the debug/DMA loader.
- Grants one access per cycle to the memory, with round-robin fairness, a bounded lock for read-modify-write, and out-of-range address trapping.
- Returns read data to the owning port with fixed one-cycle latency.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory, with bounded RMW lock and range trap.
// Grant and memory drive are combinational; read/err responses return one cycle after the grant.
module dmem_arbiter #(
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 19,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t      lock_state_q, lock_state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_port_q, resp_port_d;
    logic             resp_err_q, resp_err_d;

    logic              gnt0, gnt1, gnt_any, gnt_port;
    logic              g_we, g_lock, in_range;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [CNT_W-1:0]  new_cnt;

    // Reset gates the grant so every output is quiet while rst is high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (lock_state_q == LOCKED) begin
                gnt0 = !lock_owner_q && p0_req;
                gnt1 =  lock_owner_q && p1_req;
            end else if (p0_req && p1_req) begin
                gnt0 = !rr_ptr_q;
                gnt1 =  rr_ptr_q;
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_port = gnt1;
    assign g_we     = gnt_port ? p1_we    : p0_we;
    assign g_lock   = gnt_port ? p1_lock  : p0_lock;
    assign g_addr   = gnt_port ? p1_addr  : p0_addr;
    assign g_wdata  = gnt_port ? p1_wdata : p0_wdata;
    assign in_range = {1'b0, g_addr} < DEPTH_X;

    always_comb begin
        mem_write      = gnt_any && in_range && g_we;
        mem_read       = gnt_any && in_range && !g_we;
        mem_addr       = (gnt_any && in_range) ? g_addr : '0;
        mem_write_data = (gnt_any && in_range && g_we) ? g_wdata : '0;
    end

    // new_cnt counts the locked grant being issued now, including the one that opens the lock.
    always_comb begin
        lock_state_d = lock_state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        new_cnt      = (lock_state_q == LOCKED) ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
        resp_valid_d = gnt_any && !g_we;
        resp_err_d   = gnt_any && !in_range;
        resp_port_d  = gnt_port;
        if (gnt_any) begin
            rr_ptr_d = !gnt_port;
            if (g_lock && (new_cnt < MAX_LOCK_C)) begin
                lock_state_d = LOCKED;
                lock_owner_d = gnt_port;
                lock_cnt_d   = new_cnt;
            end else begin
                lock_state_d = UNLOCKED;
                lock_owner_d = 1'b0;
                lock_cnt_d   = '0;
            end
        end else if (lock_state_q == LOCKED) begin
            // Owner dropped its request: release and hand priority to the other port.
            lock_state_d = UNLOCKED;
            rr_ptr_d     = !lock_owner_q;
            lock_owner_d = 1'b0;
            lock_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state_q <= UNLOCKED;
            rr_ptr_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = resp_valid_q && !resp_port_q;
    assign p1_rvalid = resp_valid_q &&  resp_port_q;
    assign p0_err    = resp_err_q && !resp_port_q;
    assign p1_err    = resp_err_q &&  resp_port_q;
    assign p0_rdata  = (p0_rvalid && !resp_err_q) ? mem_read_data : '0;
    assign p1_rdata  = (p1_rvalid && !resp_err_q) ? mem_read_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected grant/memory and response records,
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        mr;
        logic        mw;
        logic [18:0] addr;
        logic [18:0] wd;
    } gexp_t;

    typedef struct packed {
        logic        port;
        logic        rv;
        logic        err;
        logic [18:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [18:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [18:0] p0_rdata, p1_rdata;
    logic [18:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic [18:0] mem [512];

    gexp_t gq[$];
    rexp_t rq[$];
    int    vectors = 0;
    int    miscompares = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Registered single-port memory: a write at edge N is visible to a read issued at edge N+1.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 512; i++)
                mem[i] <= (i == 10) ? 19'h00AAA : (i == 20) ? 19'h00BBB : 19'h0;
            mem_read_data <= '0;
        end else begin
            if (mem_write) mem[mem_addr[8:0]] <= mem_write_data;
            if (mem_read)  mem_read_data <= mem[mem_addr[8:0]];
        end
    end

    task automatic exp_rsp(input logic port, input logic rv, input logic err, input logic [18:0] data);
        rq.push_back('{port: port, rv: rv, err: err, data: data});
    endtask

    // Drives one cycle of inputs with hand-chosen expected grants; memory-drive expectation follows from them.
    task automatic step(input logic r0, input logic w0, input logic [18:0] a0, input logic [18:0] d0, input logic l0,
                        input logic r1, input logic w1, input logic [18:0] a1, input logic [18:0] d1, input logic l1,
                        input logic eg0, input logic eg1);
        gexp_t       e;
        logic        we, inr;
        logic [18:0] a, d;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_lock = l0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = l1;
        we  = eg1 ? w1 : w0;
        a   = eg1 ? a1 : a0;
        d   = eg1 ? d1 : d0;
        inr = (eg0 || eg1) && (a < 19'd512);
        e.g0   = eg0;
        e.g1   = eg1;
        e.mr   = inr && !we;
        e.mw   = inr && we;
        e.addr = inr ? a : 19'h0;
        e.wd   = (inr && we) ? d : 19'h0;
        gq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        logic [41:0] got_r, want_r;
        if (gq.size() > 0) begin
            g = gq.pop_front();
            vectors++;
            if ({p0_gnt, p1_gnt, mem_read, mem_write, mem_addr, mem_write_data} !== g) begin
                miscompares++;
                $display("FAIL gnt_mem t=%0t got g0=%b g1=%b rd=%b wr=%b addr=%h wd=%h want g0=%b g1=%b rd=%b wr=%b addr=%h wd=%h",
                         $time, p0_gnt, p1_gnt, mem_read, mem_write, mem_addr, mem_write_data,
                         g.g0, g.g1, g.mr, g.mw, g.addr, g.wd);
            end
        end
        got_r = {p0_rvalid, p0_err, p0_rdata, p1_rvalid, p1_err, p1_rdata};
        if (p0_rvalid || p0_err || p1_rvalid || p1_err) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected t=%0t got %h want no response", $time, got_r);
            end else begin
                r = rq.pop_front();
                want_r = {!r.port && r.rv, !r.port && r.err, r.port ? 19'h0 : r.data,
                           r.port && r.rv,  r.port && r.err, r.port ? r.data : 19'h0};
                if (got_r !== want_r) begin
                    miscompares++;
                    $display("FAIL resp t=%0t got %h want %h", $time, got_r, want_r);
                end
            end
        end else if (gq.size() > 0 || rq.size() > 0) begin
            vectors++;
            if (got_r !== 42'h0) begin
                miscompares++;
                $display("FAIL resp_idle t=%0t got %h want 0", $time, got_r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got timeout want completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; init = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_lock = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
        @(posedge clk);
        #1;
        init = 1'b0;
        // Requests held during reset must not be granted.
        step(1, 0, 10, 0, 0, 1, 1, 20, 19'h55, 0, 0, 0);
        step(1, 0, 10, 0, 0, 1, 1, 20, 19'h55, 0, 0, 0);
        rst = 1'b0;

        // Write then same-address read on consecutive cycles.
        step(1, 1, 5, 19'h12345, 0, 0, 0, 0, 0, 0, 1, 0);
        exp_rsp(0, 1, 0, 19'h12345);
        step(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // p1 alone moves the pointer back to p0, then both read continuously and alternate.
        exp_rsp(1, 1, 0, 19'h00BBB);
        step(0, 0, 0, 0, 0, 1, 0, 20, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_rsp(0, 1, 0, 19'h00AAA);
            else            exp_rsp(1, 1, 0, 19'h00BBB);
            step(1, 0, 10, 0, 0, 1, 0, 20, 0, 0, (i % 2 == 0), (i % 2 == 1));
        end
        idle();

        // p1 locks for three writes and releases on the fourth; p0 waits throughout.
        step(1, 1, 30, 19'h1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 10, 0, 0, 1, 1, 19'(40 + i), 19'(256 + i), (i < 3), 0, 1);
        exp_rsp(0, 1, 0, 19'h00AAA);
        step(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // p1 holds lock forever: eight grants, then forced release gives p0 the ninth cycle.
        for (int i = 0; i < 8; i++)
            step(1, 0, 20, 0, 0, 1, 1, 19'(50 + i), 19'(512 + i), 1, 0, 1);
        exp_rsp(0, 1, 0, 19'h00BBB);
        step(1, 0, 20, 0, 0, 1, 1, 58, 19'h208, 1, 1, 0);
        // Relock by p1, then it drops req: one blocked cycle for p0, then p0 granted.
        step(0, 0, 0, 0, 0, 1, 1, 59, 19'h209, 1, 0, 1);
        step(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_rsp(0, 1, 0, 19'h00BBB);
        step(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Out-of-range accesses, then the last valid address written by p1 and read by p0.
        exp_rsp(1, 0, 1, 19'h0);
        step(1, 0, 512, 0, 0, 1, 1, 600, 19'h7FFFF, 0, 0, 1);
        exp_rsp(0, 1, 1, 19'h0);
        step(1, 0, 512, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 511, 19'h7FFFF, 0, 0, 1);
        exp_rsp(0, 1, 0, 19'h7FFFF);
        step(1, 0, 511, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Reset while p1 holds the lock with a read response in flight.
        step(0, 0, 0, 0, 0, 1, 1, 60, 19'h33, 1, 0, 1);
        step(1, 0, 10, 0, 0, 1, 0, 20, 0, 1, 0, 1);
        rst = 1'b1;
        step(1, 0, 10, 0, 0, 1, 0, 20, 0, 1, 0, 0);
        step(1, 0, 10, 0, 0, 1, 0, 20, 0, 1, 0, 0);
        rst = 1'b0;
        exp_rsp(0, 1, 0, 19'h00AAA);
        step(1, 0, 10, 0, 0, 1, 0, 20, 0, 1, 1, 0);
        exp_rsp(1, 1, 0, 19'h00BBB);
        step(0, 0, 0, 0, 0, 1, 0, 20, 0, 1, 0, 1);
        idle();
        idle();

        @(negedge clk);
        #1;
        vectors++;
        if (rq.size() != 0 || gq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got rq=%0d gq=%0d want rq=0 gq=0", rq.size(), gq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
